// File: rtl/spi_minion_frontend.sv
// SPI mode-0 minion front-end: pad synchronisers, MOSI deserialiser into a small
// receive FIFO, MISO serialiser. Define SPI_MINION_PARITY_EN to add the parity output.
module spi_minion_frontend #(
  parameter int BIT_WIDTH = 8,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs,
  input  logic                 sclk,
  input  logic                 mosi,
  output logic                 miso,
  output logic [BIT_WIDTH-1:0] recv_msg,
  output logic                 recv_val,
  input  logic                 recv_rdy,
  input  logic [BIT_WIDTH-1:0] send_msg,
  input  logic                 send_val,
  output logic                 send_rdy,
  output logic                 overflow,
  output logic                 parity
);
  localparam int CW = $clog2(BIT_WIDTH);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic r_cs_m, r_cs_s, r_cs_p;
  logic r_sclk_m, r_sclk_s, r_sclk_p;
  logic r_mosi_m, r_mosi_s;

  // two-flop synchronisers; the _p stage gives edge detection on sclk and cs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {r_cs_m, r_cs_s, r_cs_p}       <= '0;
      {r_sclk_m, r_sclk_s, r_sclk_p} <= '0;
      {r_mosi_m, r_mosi_s}           <= '0;
    end else begin
      {r_cs_m, r_cs_s, r_cs_p}       <= {cs, r_cs_m, r_cs_s};
      {r_sclk_m, r_sclk_s, r_sclk_p} <= {sclk, r_sclk_m, r_sclk_s};
      {r_mosi_m, r_mosi_s}           <= {mosi, r_mosi_m};
    end
  end

  logic                 w_rise, w_fall, w_cs_fall, w_cs_rise;
  logic                 w_rx, w_tx, w_done, w_start;
  logic [CW-1:0]        r_cnt;
  logic [BIT_WIDTH-1:0] r_rx_sr, r_tx_sr, w_word;

  assign w_rise    = r_sclk_s & ~r_sclk_p;
  assign w_fall    = ~r_sclk_s & r_sclk_p;
  assign w_cs_fall = ~r_cs_s & r_cs_p;
  assign w_cs_rise = r_cs_s & ~r_cs_p;
  assign w_rx      = w_rise & ~r_cs_s;
  assign w_tx      = w_fall & ~r_cs_s;
  assign w_word    = {r_rx_sr[BIT_WIDTH-2:0], r_mosi_s};
  assign w_done    = w_rx & (r_cnt == CW'(BIT_WIDTH - 1));
  // a completed word inside the same cs window starts the next frame immediately
  assign w_start   = w_cs_fall | w_done;
  assign send_rdy  = w_start & send_val;
  assign miso      = r_tx_sr[BIT_WIDTH-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_rx_sr <= '0;
      r_tx_sr <= '0;
    end else begin
      if (w_rx) r_rx_sr <= w_word;
      if (w_cs_rise || w_cs_fall || w_done) r_cnt <= '0;
      else if (w_rx)                        r_cnt <= r_cnt + CW'(1);
      if (w_start)   r_tx_sr <= send_val ? send_msg : '0;
      else if (w_tx) r_tx_sr <= {r_tx_sr[BIT_WIDTH-2:0], 1'b0};
    end
  end

  logic [BIT_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]        r_wr, r_rd, w_count;
  logic [IW-1:0]        w_wr_idx, w_rd_idx;
  logic                 w_full, w_empty, w_pop, w_push;

  assign w_count  = r_wr - r_rd;
  assign w_full   = (w_count == PW'(DEPTH));
  assign w_empty  = (r_wr == r_rd);
  assign w_wr_idx = IW'(r_wr % PW'(DEPTH));
  assign w_rd_idx = IW'(r_rd % PW'(DEPTH));
  assign w_pop    = ~w_empty & recv_rdy;
  // a pop in the same cycle frees a slot, so a full FIFO can still accept
  assign w_push   = w_done & (~w_full | w_pop);
  assign recv_val = ~w_empty;
  assign recv_msg = r_mem[w_rd_idx];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_wr_idx] <= w_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr     <= '0;
      r_rd     <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_push)           r_wr     <= r_wr + PW'(1);
      if (w_pop)            r_rd     <= r_rd + PW'(1);
      if (w_done && !w_push) overflow <= 1'b1;
    end
  end

`ifdef SPI_MINION_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      parity <= 1'b0;
    else if (w_push) parity <= ^w_word;
  end
`else
  assign parity = 1'b0;
`endif

endmodule
